// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module  : nes_pad_reader
// Brief   : Polls a serial NES-style pad once per frame_rate request and
//           publishes registered, SOCD-cleaned, active-high button levels.
// Revision: 1.0 - initial release
// ============================================================================
module nes_pad_reader #(
    parameter int LATCH_CYCLES       = 300,
    parameter int HALF_PERIOD_CYCLES = 150,
    parameter bit SOCD_NEUTRAL       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_rate,
    input  logic ctrl_data,
    output logic ctrl_latch,
    output logic ctrl_clk,
    output logic button_a,
    output logic button_b,
    output logic button_select,
    output logic button_start,
    output logic button_up,
    output logic button_down,
    output logic button_left,
    output logic button_right,
    output logic data_valid,
    output logic busy
);

    localparam int c_CNT_MAX = (LATCH_CYCLES > HALF_PERIOD_CYCLES) ? LATCH_CYCLES
                                                                    : HALF_PERIOD_CYCLES;
    localparam int c_CNT_W   = ($clog2(c_CNT_MAX) < 1) ? 1 : $clog2(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_LATCH_LAST = c_CNT_W'(LATCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(HALF_PERIOD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LATCH = 3'd1;
    localparam logic [2:0] c_ST_LOW   = 3'd2;
    localparam logic [2:0] c_ST_HIGH  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_phase_cnt;
    logic [2:0]         r_bit_cnt;
    logic [1:0]         r_sync;
    logic [7:0]         r_shift;
    logic [7:0]         r_buttons;
    logic               r_ctrl_latch;
    logic               r_ctrl_clk;
    logic               r_data_valid;
    logic               r_busy;

    logic               w_sample;
    logic               w_load;
    logic               w_latch_next;
    logic               w_clk_next;
    logic               w_busy_next;
    logic [7:0]         w_pressed;
    logic [7:0]         w_clean;

    // State register with per-phase cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_phase_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state || r_state == c_ST_IDLE) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state logic; bit counter wraps to 0 after the 8th sample
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (frame_rate) begin
                    w_state_next = c_ST_LATCH;
                end
            end
            c_ST_LATCH: begin
                if (r_phase_cnt == c_LATCH_LAST) begin
                    w_state_next = c_ST_LOW;
                end
            end
            c_ST_LOW: begin
                if (r_phase_cnt == c_HALF_LAST) begin
                    w_state_next = c_ST_HIGH;
                end
            end
            c_ST_HIGH: begin
                if (r_phase_cnt == c_HALF_LAST) begin
                    w_state_next = (r_bit_cnt == 3'd0) ? c_ST_DONE : c_ST_LOW;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so pad lines and flags come straight off flops
    always_comb begin
        w_sample     = (r_state == c_ST_LOW) && (r_phase_cnt == c_HALF_LAST);
        w_load       = (w_state_next == c_ST_DONE);
        w_latch_next = (w_state_next == c_ST_LATCH);
        w_clk_next   = (w_state_next != c_ST_LOW);
        w_busy_next  = (w_state_next != c_ST_IDLE);
    end

    assign w_pressed = ~r_shift;

    generate
        if (SOCD_NEUTRAL) begin : g_socd
            always_comb begin
                w_clean = w_pressed;
                if (w_pressed[4] && w_pressed[5]) begin
                    w_clean[5:4] = 2'b00;
                end
                if (w_pressed[6] && w_pressed[7]) begin
                    w_clean[7:6] = 2'b00;
                end
            end
        end else begin : g_raw
            assign w_clean = w_pressed;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= 2'b00;
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_buttons    <= 8'h00;
            r_ctrl_latch <= 1'b0;
            r_ctrl_clk   <= 1'b1;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], ctrl_data};
            r_ctrl_latch <= w_latch_next;
            r_ctrl_clk   <= w_clk_next;
            r_data_valid <= w_load;
            r_busy       <= w_busy_next;
            // Bit 0 arrives first, so shift toward the LSB
            if (w_sample) begin
                r_shift   <= {r_sync[1], r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_load) begin
                r_buttons <= w_clean;
            end
        end
    end

    assign ctrl_latch    = r_ctrl_latch;
    assign ctrl_clk      = r_ctrl_clk;
    assign data_valid    = r_data_valid;
    assign busy          = r_busy;
    assign button_a      = r_buttons[0];
    assign button_b      = r_buttons[1];
    assign button_select = r_buttons[2];
    assign button_start  = r_buttons[3];
    assign button_up     = r_buttons[4];
    assign button_down   = r_buttons[5];
    assign button_left   = r_buttons[6];
    assign button_right  = r_buttons[7];

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_nes_pad_reader
// Brief   : Directed bench for nes_pad_reader with a shift-register pad model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nes_pad_reader;

    localparam int c_L    = 4;
    localparam int c_H    = 4;
    localparam int c_DONE = c_L + 16 * c_H + 1;

    typedef struct {
        logic [7:0] pad;
        bit         conn;
        logic [7:0] exp_socd;
        logic [7:0] exp_raw;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_rate = 1'b0;
    wire  ctrl_data;

    logic ctrl_latch, ctrl_clk, data_valid, busy;
    logic button_a, button_b, button_select, button_start;
    logic button_up, button_down, button_left, button_right;
    logic latch_n, clk_n, dv_n, busy_n;
    logic a_n, b_n, sel_n, st_n, up_n, dn_n, lf_n, rt_n;

    logic [7:0] pad_bits = 8'hFF;
    logic [7:0] pad_sr = 8'hFF;
    logic       pad_prev_clk = 1'b1;
    bit         pad_connected = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    int         latch_cnt, latch_first, low_pulses, dv_cnt, dv_cyc;
    logic       busy_c1, busy_end;
    logic [7:0] btn_before;
    vec_t       vecs [7];

    wire [7:0] btn_s = {button_right, button_left, button_down, button_up,
                        button_start, button_select, button_b, button_a};
    wire [7:0] btn_n = {rt_n, lf_n, dn_n, up_n, st_n, sel_n, b_n, a_n};

    always #5 clk = ~clk;

    nes_pad_reader #(.LATCH_CYCLES(c_L), .HALF_PERIOD_CYCLES(c_H), .SOCD_NEUTRAL(1'b1)) dut (
        .clk(clk), .reset(reset), .frame_rate(frame_rate), .ctrl_data(ctrl_data),
        .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk),
        .button_a(button_a), .button_b(button_b), .button_select(button_select),
        .button_start(button_start), .button_up(button_up), .button_down(button_down),
        .button_left(button_left), .button_right(button_right),
        .data_valid(data_valid), .busy(busy)
    );

    nes_pad_reader #(.LATCH_CYCLES(c_L), .HALF_PERIOD_CYCLES(c_H), .SOCD_NEUTRAL(1'b0)) dut_n (
        .clk(clk), .reset(reset), .frame_rate(frame_rate), .ctrl_data(ctrl_data),
        .ctrl_latch(latch_n), .ctrl_clk(clk_n),
        .button_a(a_n), .button_b(b_n), .button_select(sel_n),
        .button_start(st_n), .button_up(up_n), .button_down(dn_n),
        .button_left(lf_n), .button_right(rt_n),
        .data_valid(dv_n), .busy(busy_n)
    );

    // 4021-style pad: parallel load while latched, shift on each rising pad clock
    always @(posedge clk) begin
        pad_prev_clk <= ctrl_clk;
        if (ctrl_latch) begin
            pad_sr <= pad_bits;
        end else if (ctrl_clk && !pad_prev_clk) begin
            pad_sr <= {1'b1, pad_sr[7:1]};
        end
    end

    assign ctrl_data = pad_connected ? pad_sr[0] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // frame_rate high during cycle 0, optional extra pulses, observe cycles 1..window
    task automatic poll(input logic [7:0] pad, input bit conn, input int x1,
                        input int x2, input int window);
        logic prev;
        pad_bits      = pad;
        pad_connected = conn;
        latch_cnt     = 0;
        latch_first   = -1;
        low_pulses    = 0;
        dv_cnt        = 0;
        dv_cyc        = -1;
        busy_c1       = 1'b0;
        busy_end      = 1'b0;
        btn_before    = 8'h00;
        @(negedge clk);
        frame_rate = 1'b1;
        prev       = ctrl_clk;
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            frame_rate = (c == x1) || (c == x2);
            if (ctrl_latch) begin
                latch_cnt++;
                if (latch_first < 0) latch_first = c;
            end
            if (prev && !ctrl_clk) low_pulses++;
            prev = ctrl_clk;
            if (data_valid) begin
                dv_cnt++;
                dv_cyc = c;
            end
            if (c == 1) busy_c1 = busy;
            if (c == c_DONE - 1) btn_before = btn_s;
            busy_end = busy;
        end
        frame_rate = 1'b0;
    endtask

    initial begin
        logic [7:0] prev_exp;
        int         dv_seen;
        int         latch_seen;

        vecs[0] = '{pad: 8'h7E, conn: 1'b1, exp_socd: 8'h81, exp_raw: 8'h81};
        vecs[1] = '{pad: 8'h2F, conn: 1'b1, exp_socd: 8'h10, exp_raw: 8'hD0};
        vecs[2] = '{pad: 8'hC5, conn: 1'b1, exp_socd: 8'h0A, exp_raw: 8'h3A};
        vecs[3] = '{pad: 8'h00, conn: 1'b1, exp_socd: 8'h0F, exp_raw: 8'hFF};
        vecs[4] = '{pad: 8'hF7, conn: 1'b1, exp_socd: 8'h08, exp_raw: 8'h08};
        vecs[5] = '{pad: 8'h00, conn: 1'b0, exp_socd: 8'h00, exp_raw: 8'h00};
        vecs[6] = '{pad: 8'h9B, conn: 1'b1, exp_socd: 8'h64, exp_raw: 8'h64};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_latch", ctrl_latch, 0);
        check("rst_clk", ctrl_clk, 1);
        check("rst_buttons", btn_s, 8'h00);
        check("rst_buttons_n", btn_n, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        prev_exp = 8'h00;
        for (int i = 0; i < 7; i++) begin
            poll(vecs[i].pad, vecs[i].conn, -1, -1, 72);
            check($sformatf("v%0d_buttons", i), btn_s, vecs[i].exp_socd);
            check($sformatf("v%0d_buttons_nosocd", i), btn_n, vecs[i].exp_raw);
            check($sformatf("v%0d_hold", i), btn_before, prev_exp);
            check($sformatf("v%0d_valid_cycle", i), dv_cyc, c_DONE);
            check($sformatf("v%0d_valid_count", i), dv_cnt, 1);
            check($sformatf("v%0d_latch_first", i), latch_first, 1);
            check($sformatf("v%0d_latch_count", i), latch_cnt, c_L);
            check($sformatf("v%0d_clk_pulses", i), low_pulses, 8);
            check($sformatf("v%0d_busy", i), busy_c1, 1);
            prev_exp = vecs[i].exp_socd;
        end

        // Requests during a poll (including its DONE cycle) are dropped
        poll(8'hF7, 1'b1, 20, c_DONE, 72);
        check("drop_latch_count", latch_cnt, c_L);
        check("drop_valid_count", dv_cnt, 1);
        check("drop_valid_cycle", dv_cyc, c_DONE);
        check("drop_busy_after", busy_end, 0);
        check("drop_buttons", btn_s, 8'h08);

        poll(8'hFE, 1'b1, -1, -1, 72);
        check("reaccept_valid_cycle", dv_cyc, c_DONE);
        check("reaccept_buttons", btn_s, 8'h01);

        poll(8'hF7, 1'b1, -1, -1, 72);
        check("pre_reset_start", button_start, 1);

        // Mid-poll reset while the pad clock is low
        pad_bits = 8'h00;
        dv_seen  = 0;
        @(negedge clk);
        frame_rate = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            frame_rate = 1'b0;
            if (data_valid) dv_seen++;
        end
        check("midpoll_clk_low", ctrl_clk, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_clk", ctrl_clk, 1);
        check("midrst_latch", ctrl_latch, 0);
        check("midrst_start", button_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", data_valid, 0);
        reset = 1'b0;
        latch_seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (data_valid) dv_seen++;
            if (ctrl_latch) latch_seen++;
        end
        check("midrst_no_valid", dv_seen, 0);
        check("midrst_idle", latch_seen, 0);
        check("midrst_buttons", btn_s, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
